// File: rtl/bus_hs_pkg.sv
// Shared definitions for the req/gnt/done/dly bus handshake.
//   - Requester state encoding (2 bits).
//   - Arbiter state encoding, so that arbiter models can reuse the same names.
//   - Default field widths for the requester.
package bus_hs_pkg;

  typedef enum logic [1:0] {
    REQ_IDLE = 2'd0,
    REQ_REQ  = 2'd1,
    REQ_XFER = 2'd2,
    REQ_HOLD = 2'd3
  } req_state_e;

  typedef enum logic [1:0] {
    ARB_FREE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  localparam int DEF_LEN_W  = 4;
  localparam int DEF_HOLD_W = 3;

endpackage

// File: rtl/bus_hs_cnt.sv
// Loadable up-counter with enable and terminal compare.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (count clears to 0)
//   load       : load load_val this cycle (has priority over en)
//   load_val   : value loaded when load=1
//   en         : increment by one
//   term       : terminal value compared against the current count
//   cnt        : current count (registered)
//   hit        : cnt == term
// With SAT=1 the counter sticks at all-ones instead of wrapping.
module bus_hs_cnt #(
  parameter int W   = 4,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         hit
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !(SAT && (&cnt_q))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign hit = (cnt_q == term);

endmodule

// File: rtl/bus_requester.sv
// Initiator end of the req/gnt/done/dly bus handshake.
// Accepts one command (burst length, post-burst hold), requests the bus,
// transfers cmd_len+1 beats while gnt is high, flags the last beat with done,
// optionally keeps dly high for cmd_hold cycles, then returns to idle.
// A request that is not granted within TMO_CYC cycles is aborted with tmo_err.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   cmd_valid/ready    : command handshake (ready only in IDLE)
//   cmd_len            : beats-1 of the burst
//   cmd_hold           : dly cycles after the last beat (0 = none)
//   gnt                : grant from the arbiter
//   req, done, dly     : handshake outputs to the arbiter
//   beat, beat_idx     : beat transferred this cycle and its 0-based index
//   busy               : not idle
//   tmo_err            : one-cycle pulse on grant timeout abort
module bus_requester
  import bus_hs_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int HOLD_W  = DEF_HOLD_W,
  parameter int TMO_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              gnt,
  output logic              req,
  output logic              done,
  output logic              dly,
  output logic              beat,
  output logic [LEN_W-1:0]  beat_idx,
  output logic              busy,
  output logic              tmo_err
);

  localparam int                WAIT_W   = $clog2(TMO_CYC);
  localparam logic [WAIT_W-1:0] TMO_TERM = WAIT_W'(TMO_CYC - 1);

  req_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic              accept;
  logic              beat_fire;
  logic              last_fire;
  logic              beat_hit;
  logic              hold_hit;
  logic              wait_hit;
  logic [LEN_W-1:0]  beat_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  assign accept    = (state_q == REQ_IDLE) && cmd_valid;
  assign beat_fire = (state_q == REQ_XFER) && gnt;
  assign last_fire = beat_fire && beat_hit;

  // Beat counter: cleared on accept and after the last beat so beat_idx
  // reads 0 outside a burst; it stops at len_q and so never wraps.
  bus_hs_cnt #(.W(LEN_W), .SAT(1'b0)) u_beat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept || last_fire),
    .load_val ('0),
    .en       (beat_fire && !beat_hit),
    .term     (len_q),
    .cnt      (beat_cnt),
    .hit      (beat_hit)
  );

  // Hold counter: preset to 1 on the last beat so that in HOLD it reads the
  // number of dly cycles issued so far; leaving HOLD when it equals hold_q.
  bus_hs_cnt #(.W(HOLD_W), .SAT(1'b0)) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept || last_fire),
    .load_val (last_fire ? HOLD_W'(1) : '0),
    .en       ((state_q == REQ_HOLD) && !hold_hit),
    .term     (hold_q),
    .cnt      (hold_cnt),
    .hit      (hold_hit)
  );

  // Grant wait counter: reads k on the k-th REQ cycle (0-based).
  bus_hs_cnt #(.W(WAIT_W), .SAT(1'b1)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val ('0),
    .en       (state_q == REQ_REQ),
    .term     (TMO_TERM),
    .cnt      (wait_cnt),
    .hit      (wait_hit)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hold_d    = hold_q;
    cmd_ready = 1'b0;
    req       = 1'b0;
    done      = 1'b0;
    dly       = 1'b0;
    beat      = 1'b0;
    tmo_err   = 1'b0;
    unique case (state_q)
      REQ_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          len_d   = cmd_len;
          hold_d  = cmd_hold;
          state_d = REQ_REQ;
        end
      end
      REQ_REQ: begin
        req = 1'b1;
        // A grant wins over a timeout landing on the same cycle.
        if (gnt) begin
          state_d = REQ_XFER;
        end else if (wait_hit) begin
          tmo_err = 1'b1;
          state_d = REQ_IDLE;
        end
      end
      REQ_XFER: begin
        beat = gnt;
        if (last_fire) begin
          done    = 1'b1;
          dly     = (hold_q != '0);
          state_d = (hold_q != '0) ? REQ_HOLD : REQ_IDLE;
        end else begin
          req = 1'b1;
        end
      end
      REQ_HOLD: begin
        dly = 1'b1;
        if (hold_hit) begin
          state_d = REQ_IDLE;
        end
      end
      default: state_d = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= REQ_IDLE;
      len_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
    end
  end

  assign beat_idx = beat_cnt;
  assign busy     = (state_q != REQ_IDLE);

endmodule

// File: tb/tb_bus_requester.sv
// Directed testbench for bus_requester with a small arbiter model.
// The arbiter grants one cycle after req, releases on done, and waits while
// dly is high. stall drops gnt; block keeps the arbiter from granting.
module tb_bus_requester;
  import bus_hs_pkg::*;

  bit          clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_hold;
  logic        gnt;
  logic        req;
  logic        done;
  logic        dly;
  logic        beat;
  logic [3:0]  beat_idx;
  logic        busy;
  logic        tmo_err;

  logic        gnt_r;
  logic        stall;
  logic        block;
  arb_state_e  arb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_requester #(.LEN_W(4), .HOLD_W(3), .TMO_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_hold  (cmd_hold),
    .gnt       (gnt),
    .req       (req),
    .done      (done),
    .dly       (dly),
    .beat      (beat),
    .beat_idx  (beat_idx),
    .busy      (busy),
    .tmo_err   (tmo_err)
  );

  // Arbiter model
  assign gnt = gnt_r && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arb   <= ARB_FREE;
      gnt_r <= 1'b0;
    end else begin
      case (arb)
        ARB_FREE: if (req && !block) begin
          arb   <= ARB_BUSY;
          gnt_r <= 1'b1;
        end
        ARB_BUSY: if (done) begin
          gnt_r <= 1'b0;
          arb   <= dly ? ARB_WAIT : ARB_FREE;
        end
        ARB_WAIT: if (!dly) arb <= ARB_FREE;
        default:  arb <= ARB_FREE;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check all outputs of the current cycle, then advance to the next slot
  // (1 time unit after the following negedge).
  task automatic chk_cyc(input string tag, input bit e_rdy, input bit e_busy,
                         input bit e_req, input bit e_beat, input logic [3:0] e_idx,
                         input bit e_done, input bit e_dly, input bit e_tmo);
    #1;
    chk({tag, ".rdy"},  32'(cmd_ready), 32'(e_rdy));
    chk({tag, ".busy"}, 32'(busy),      32'(e_busy));
    chk({tag, ".req"},  32'(req),       32'(e_req));
    chk({tag, ".beat"}, 32'(beat),      32'(e_beat));
    chk({tag, ".idx"},  32'(beat_idx),  32'(e_idx));
    chk({tag, ".done"}, 32'(done),      32'(e_done));
    chk({tag, ".dly"},  32'(dly),       32'(e_dly));
    chk({tag, ".tmo"},  32'(tmo_err),   32'(e_tmo));
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_hold = '0;
    stall = 1'b0; block = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    // Reset state
    chk("rst.arb", 32'(arb), 32'(ARB_FREE));
    chk_cyc("rst", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    rst_n = 1'b1;

    // Basic burst: 4 beats, no hold
    cmd_valid = 1'b1; cmd_len = 4'd3; cmd_hold = 3'd0;
    chk_cyc("b_idle", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cmd_valid = 1'b0;
    chk_cyc("b_req0", 0, 1, 1, 0, 4'd0, 0, 0, 0);
    chk_cyc("b_req1", 0, 1, 1, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      chk_cyc($sformatf("b_x%0d", i), 0, 1, i != 3, 1, 4'(i), i == 3, 0, 0);
    chk_cyc("b_end", 1, 0, 0, 0, 4'd0, 0, 0, 0);

    // Hold phase: 2 beats then 3 dly cycles
    cmd_valid = 1'b1; cmd_len = 4'd1; cmd_hold = 3'd3;
    chk_cyc("h_idle", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cmd_valid = 1'b0;
    chk_cyc("h_req0", 0, 1, 1, 0, 4'd0, 0, 0, 0);
    chk("h.arb_busy", 32'(arb), 32'(ARB_BUSY));
    chk_cyc("h_req1", 0, 1, 1, 0, 4'd0, 0, 0, 0);
    chk_cyc("h_x0", 0, 1, 1, 1, 4'd0, 0, 0, 0);
    chk_cyc("h_x1", 0, 1, 0, 1, 4'd1, 1, 1, 0);
    chk("h.arb_wait0", 32'(arb), 32'(ARB_WAIT));
    for (int i = 0; i < 3; i++)
      chk_cyc($sformatf("h_hold%0d", i), 0, 1, 0, 0, 4'd0, 0, 1, 0);
    chk("h.arb_wait1", 32'(arb), 32'(ARB_WAIT));
    chk_cyc("h_end", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    chk("h.arb_free", 32'(arb), 32'(ARB_FREE));

    // Stall: gnt dropped for 2 cycles after beat 0
    cmd_valid = 1'b1; cmd_len = 4'd2; cmd_hold = 3'd0;
    chk_cyc("s_idle", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cmd_valid = 1'b0;
    chk_cyc("s_req0", 0, 1, 1, 0, 4'd0, 0, 0, 0);
    chk_cyc("s_req1", 0, 1, 1, 0, 4'd0, 0, 0, 0);
    chk_cyc("s_x0", 0, 1, 1, 1, 4'd0, 0, 0, 0);
    stall = 1'b1;
    chk_cyc("s_st0", 0, 1, 1, 0, 4'd1, 0, 0, 0);
    chk_cyc("s_st1", 0, 1, 1, 0, 4'd1, 0, 0, 0);
    stall = 1'b0;
    chk_cyc("s_x1", 0, 1, 1, 1, 4'd1, 0, 0, 0);
    chk_cyc("s_x2", 0, 1, 0, 1, 4'd2, 1, 0, 0);
    chk_cyc("s_end", 1, 0, 0, 0, 4'd0, 0, 0, 0);

    // Timeout: no grant, req high for 16 cycles
    block = 1'b1; cmd_valid = 1'b1; cmd_len = 4'd5; cmd_hold = 3'd2;
    chk_cyc("t_idle", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cmd_valid = 1'b0;
    for (int i = 1; i <= 16; i++)
      chk_cyc($sformatf("t_req%0d", i), 0, 1, 1, 0, 4'd0, 0, 0, i == 16);
    block = 1'b0; cmd_valid = 1'b1; cmd_len = 4'd0; cmd_hold = 3'd0;
    chk_cyc("t_idle2", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cmd_valid = 1'b0;
    chk_cyc("t_req_a", 0, 1, 1, 0, 4'd0, 0, 0, 0);
    chk_cyc("t_req_b", 0, 1, 1, 0, 4'd0, 0, 0, 0);
    chk_cyc("t_x0", 0, 1, 0, 1, 4'd0, 1, 0, 0);
    chk_cyc("t_end", 1, 0, 0, 0, 4'd0, 0, 0, 0);

    // Back-to-back single-beat bursts with cmd_valid held high
    cmd_valid = 1'b1; cmd_len = 4'd0; cmd_hold = 3'd0;
    for (int b = 0; b < 3; b++) begin
      chk_cyc($sformatf("bb%0d_idle", b), 1, 0, 0, 0, 4'd0, 0, 0, 0);
      chk_cyc($sformatf("bb%0d_req0", b), 0, 1, 1, 0, 4'd0, 0, 0, 0);
      chk_cyc($sformatf("bb%0d_req1", b), 0, 1, 1, 0, 4'd0, 0, 0, 0);
      chk_cyc($sformatf("bb%0d_x", b),    0, 1, 0, 1, 4'd0, 1, 0, 0);
    end
    cmd_valid = 1'b0;
    chk_cyc("bb_idle_a", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    chk_cyc("bb_idle_b", 1, 0, 0, 0, 4'd0, 0, 0, 0);

    // Reset mid-burst
    cmd_valid = 1'b1; cmd_len = 4'd3; cmd_hold = 3'd1;
    chk_cyc("r_idle", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cmd_valid = 1'b0;
    chk_cyc("r_req0", 0, 1, 1, 0, 4'd0, 0, 0, 0);
    chk_cyc("r_req1", 0, 1, 1, 0, 4'd0, 0, 0, 0);
    chk_cyc("r_x0", 0, 1, 1, 1, 4'd0, 0, 0, 0);
    rst_n = 1'b0;
    chk_cyc("r_x1", 0, 1, 1, 1, 4'd1, 0, 0, 0);
    rst_n = 1'b1;
    chk("r.arb", 32'(arb), 32'(ARB_FREE));
    chk_cyc("r_after", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    chk_cyc("r_idle2", 1, 0, 0, 0, 4'd0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
